// File: rtl/if_pkg.sv
// Shared fetch-path types for the instruction fetch response stage.
//   ifr_state_e   : response-stage control state
//   fetch_entry_t : one buffered fetch result {pc, inst, fault}
//   NOP_INST      : instruction shown when nothing valid is presented
package if_pkg;

  localparam int PC_W   = 64;
  localparam int INST_W = 32;

  localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    INIT   = 2'd0,
    RUN    = 2'd1,
    DWAIT  = 2'd2,
    DDRAIN = 2'd3
  } ifr_state_e;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
    logic              fault;
  } fetch_entry_t;

  // Instructions are 4-byte aligned; any low address bit set is a fault.
  function automatic logic pc_misaligned(input logic [1:0] pc_lo);
    return pc_lo != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries with flush.
//   clk, reset   : clock, asynchronous active-high reset (pointers/count only)
//   flush        : empties the FIFO; wins over push and pop in the same cycle
//   push         : write push_entry at the tail
//   pop          : retire the head entry (ignored when empty)
//   head_entry   : registered head entry, no write-to-read bypass
//   count        : number of valid entries
module fetch_fifo
  import if_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  push,
  input  fetch_entry_t          push_entry,
  input  logic                  pop,
  output fetch_entry_t          head_entry,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    do_push  = push & ~flush;
    do_pop   = pop & ~flush & (count_q != '0);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // DEPTH is a power of two, so pointer overflow is the modulo wrap.
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries data only; it needs no reset because count gates it.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_entry;
  end

  assign head_entry = mem_q[rd_ptr_q];
  assign count      = count_q;

  // Upstream stall_req must make a push into a full FIFO impossible.
  no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(do_push && (count_q == FULL_CNT)))
    else $fatal(1, "fetch_fifo overflow");

endmodule

// File: rtl/pipeline_ifr_stage2.sv
// Instruction fetch response stage.
// Captures the fetched word for pc_IFP from ROM or DRAM (channel registered
// here from stage1's selection), buffers it in a small FIFO toward ID, drops
// wrong-path responses on branch_taken, and asks stage1 to hold its PC.
//   clk, reset       : clock, asynchronous active-high reset
//   if_channel_sel   : stage1 channel for pc_next (1=DRAM, 0=ROM)
//   pc_IFP           : address whose response arrives this cycle
//   fetch_issue      : stage1 advanced its PC at the last edge
//   rom_rdata        : ROM read data (1-cycle latency)
//   dram_rdata       : 64-bit DRAM read data
//   dram_rvalid      : DRAM read data valid
//   branch_taken     : flush wrong-path fetches
//   stall_in         : ID not accepting this cycle
//   inst_IF, pc_IF   : head instruction and its PC
//   valid_IF         : head valid
//   fetch_fault      : head PC misaligned
//   stall_req        : hold stage1 PC
module pipeline_ifr_stage2
  import if_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int XLEN       = 64,
  parameter int ILEN       = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            if_channel_sel,
  input  logic [XLEN-1:0] pc_IFP,
  input  logic            fetch_issue,
  input  logic [ILEN-1:0] rom_rdata,
  input  logic [XLEN-1:0] dram_rdata,
  input  logic            dram_rvalid,
  input  logic            branch_taken,
  input  logic            stall_in,
  output logic [ILEN-1:0] inst_IF,
  output logic [XLEN-1:0] pc_IF,
  output logic            valid_IF,
  output logic            fetch_fault,
  output logic            stall_req
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] ALMOST_CNT = CNT_W'(FIFO_DEPTH - 1);

  ifr_state_e       state_q, state_d;
  logic             ch_q, ch_d;
  logic             issue_q, issue_d;

  logic             resp_v;
  logic [ILEN-1:0]  word;
  logic             fault;
  logic             push;
  logic             fsm_stall;
  fetch_entry_t     push_entry;
  fetch_entry_t     head_entry;
  logic [CNT_W-1:0] fifo_count;

  // Response capture: channel for the response in flight is ch_q.
  always_comb begin
    resp_v = ch_q ? dram_rvalid : issue_q;
    if (ch_q) word = pc_IFP[2] ? dram_rdata[2*ILEN-1:ILEN] : dram_rdata[ILEN-1:0];
    else      word = rom_rdata;
    fault            = pc_misaligned(pc_IFP[1:0]);
    push_entry.pc    = pc_IFP;
    push_entry.inst  = fault ? NOP_INST : word;
    push_entry.fault = fault;
  end

  // Control FSM. A DRAM fetch that has not returned in the cycle after issue
  // holds stage1 right away, so pc_IFP stays on the address being read and
  // its bit 2 still selects the correct half of dram_rdata.
  always_comb begin
    state_d   = state_q;
    push      = 1'b0;
    fsm_stall = 1'b0;
    unique case (state_q)
      INIT: state_d = RUN;
      RUN: begin
        if (ch_q) begin
          if (dram_rvalid) begin
            push = ~branch_taken;
          end else if (issue_q) begin
            fsm_stall = 1'b1;
            state_d   = branch_taken ? DDRAIN : DWAIT;
          end
        end else begin
          push = issue_q & ~branch_taken;
        end
      end
      DWAIT: begin
        fsm_stall = 1'b1;
        if (dram_rvalid) begin
          push    = ~branch_taken;
          state_d = RUN;
        end else if (branch_taken) begin
          state_d = DDRAIN;
        end
      end
      DDRAIN: begin
        // The read already issued must still be absorbed; its data is dropped.
        fsm_stall = 1'b1;
        if (dram_rvalid) state_d = RUN;
      end
      default: state_d = INIT;
    endcase
  end

  always_comb begin
    stall_req = (fifo_count == FULL_CNT)
              | ((fifo_count == ALMOST_CNT) & stall_in & resp_v)
              | fsm_stall;
    ch_d      = stall_req ? ch_q : if_channel_sel;
    issue_d   = fetch_issue;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= INIT;
      ch_q    <= 1'b0;
      issue_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      issue_q <= issue_d;
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .flush      (branch_taken),
    .push       (push),
    .push_entry (push_entry),
    .pop        (valid_IF & ~stall_in),
    .head_entry (head_entry),
    .count      (fifo_count)
  );

  // Head presentation: NOP / PC 0 whenever nothing is valid.
  always_comb begin
    valid_IF    = (fifo_count != '0);
    inst_IF     = valid_IF ? head_entry.inst : NOP_INST;
    pc_IF       = valid_IF ? head_entry.pc   : '0;
    fetch_fault = valid_IF & head_entry.fault;
  end

endmodule
